// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Purpose  : Execute/Decode-side bundle for the iterative mul/div unit.
//            The master side is the pipeline, which drives operations and
//            moves. The slave side is the unit, which returns HI/LO, busy
//            and the stall request.
// Revision : 1.0  initial release
// ============================================================================
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             mthiE;
  logic             mtloE;
  logic             hiloreadD;
  logic             muldivD;
  logic             busy;
  logic             mdstall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output startE, opE, srcaE, srcbE, mthiE, mtloE, hiloreadD, muldivD,
    input  busy, mdstall, hi, lo, divzero
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, mthiE, mtloE, hiloreadD, muldivD,
    output busy, mdstall, hi, lo, divzero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
//            It retires one bit per cycle, so every operation takes exactly
//            32 cycles. The unit raises a stall request while an operation
//            is in flight.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic reset_n,
  muldiv_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [5:0]           r_count;
  logic [WIDTH-1:0]     r_amag;      // |a| for signed ops, raw a for unsigned
  logic [WIDTH-1:0]     r_bmag;      // |b| for signed ops, raw b for unsigned
  logic                 r_sa;        // a was negative (signed ops only)
  logic                 r_sb;        // b was negative (signed ops only)
  logic [2*WIDTH-1:0]   r_acc;       // MUL: {partial product, multiplier}; DIV: low half = dividend -> quotient
  logic [WIDTH:0]       r_rem;       // DIV partial remainder
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_divzero;

  logic                 w_idle;
  logic                 w_start;
  logic                 w_last;
  logic                 w_signed;
  logic                 w_sa_in;
  logic                 w_sb_in;
  logic [WIDTH-1:0]     w_amag_in;
  logic [WIDTH-1:0]     w_bmag_in;
  logic [WIDTH:0]       w_msum;
  logic [2*WIDTH-1:0]   w_mstep;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH+1:0]     w_dshift;
  logic [WIDTH+1:0]     w_ddiff;
  logic                 w_qbit;
  logic [WIDTH:0]       w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_a_raw;

  assign w_idle    = (r_state == S_IDLE);
  assign w_start   = w_idle & bus.startE;
  assign w_last    = (r_count == 6'd31);

  // Operand capture: only MULT/DIV (opE[0]=0) treat operands as signed.
  assign w_signed  = ~bus.opE[0];
  assign w_sa_in   = w_signed & bus.srcaE[WIDTH-1];
  assign w_sb_in   = w_signed & bus.srcbE[WIDTH-1];
  assign w_amag_in = w_sa_in ? (-bus.srcaE) : bus.srcaE;
  assign w_bmag_in = w_sb_in ? (-bus.srcbE) : bus.srcbE;

  // Shift-add step: add the multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_amag} : {(WIDTH+1){1'b0}});
  assign w_mstep    = {w_msum, r_acc[WIDTH-1:1]};
  assign w_prod_fix = (r_sa ^ r_sb) ? (-w_mstep) : w_mstep;

  // Restoring step: bring in the next dividend bit and trial-subtract.
  // A borrow lands in the top bit of the extra-wide difference.
  assign w_dshift   = {r_rem, r_acc[WIDTH-1]};
  assign w_ddiff    = w_dshift - {2'b00, r_bmag};
  assign w_qbit     = ~w_ddiff[WIDTH+1];
  assign w_rem_next = w_qbit ? w_ddiff[WIDTH:0] : w_dshift[WIDTH:0];
  assign w_quo_next = {r_acc[WIDTH-2:0], w_qbit};
  assign w_quo_fix  = (r_sa ^ r_sb) ? (-w_quo_next) : w_quo_next;
  assign w_rem_fix  = r_sa ? (-w_rem_next[WIDTH-1:0]) : w_rem_next[WIDTH-1:0];

  // The original a is rebuilt from sign and magnitude for the divide-by-zero HI.
  assign w_a_raw    = r_sa ? (-r_amag) : r_amag;

  assign bus.busy    = ~w_idle;
  assign bus.mdstall = ~w_idle & (bus.hiloreadD | bus.muldivD);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.divzero = r_divzero;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: a start picks MUL or DIV; the 32nd iteration returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:       if (bus.startE) w_state_next = bus.opE[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (w_last)     w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fixup and HI/LO write-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= 6'd0;
      r_amag    <= '0;
      r_bmag    <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_divzero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_amag    <= w_amag_in;
            r_bmag    <= w_bmag_in;
            r_sa      <= w_sa_in;
            r_sb      <= w_sb_in;
            r_count   <= 6'd0;
            r_rem     <= '0;
            r_divzero <= 1'b0;
            r_acc     <= {{WIDTH{1'b0}}, (bus.opE[1] ? w_amag_in : w_bmag_in)};
          end else begin
            if (bus.mthiE) r_hi <= bus.srcaE;
            if (bus.mtloE) r_lo <= bus.srcaE;
          end
        end
        S_MUL: begin
          r_count <= r_count + 6'd1;
          r_acc   <= w_mstep;
          if (w_last) begin
            r_count <= 6'd0;
            r_hi    <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod_fix[WIDTH-1:0];
          end
        end
        S_DIV: begin
          r_count <= r_count + 6'd1;
          r_rem   <= w_rem_next;
          r_acc   <= {r_acc[2*WIDTH-1:WIDTH], w_quo_next};
          if (w_last) begin
            r_count <= 6'd0;
            if (r_bmag == '0) begin
              r_lo      <= '1;
              r_hi      <= w_a_raw;
              r_divzero <= 1'b1;
            end else begin
              r_lo      <= w_quo_fix;
              r_hi      <= w_rem_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed scoreboard bench for muldiv_unit. The stimulus process
//            queues expected HI/LO/divzero for each operation. The monitor
//            pops one entry and compares it on each busy falling edge, and
//            it also checks that busy stayed high for exactly 32 cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int          WIDTH = 32;
  localparam logic [1:0]  OP_MULT  = 2'b00;
  localparam logic [1:0]  OP_MULTU = 2'b01;
  localparam logic [1:0]  OP_DIV   = 2'b10;
  localparam logic [1:0]  OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic   clk;
  logic   reset_n;
  exp_t   sb_q[$];
  int     n_checks;
  int     n_fail;

  muldiv_if #(.WIDTH(WIDTH)) bus();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation. startE is high for one rising edge (edge N).
  // The task returns at the falling edge just after edge N.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                          input bit push);
    exp_t e;
    @(negedge clk);
    bus.startE = 1'b1;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dz = edz;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.startE = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: busy still %0b after 40 cycles, required 0", bus.busy);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    start_op(op, a, b, ehi, elo, edz, 1'b1);
    wait_done();
  endtask

  // Monitor: count busy cycles and score each completion.
  initial begin : monitor
    bit   prev_busy;
    int   run;
    exp_t e;
    prev_busy = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_busy = 1'b0;
        run = 0;
      end else begin
        if (bus.busy) begin
          run++;
        end else if (prev_busy) begin
          check("busy_cycles", 64'(run), 64'd32);
          if (sb_q.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
            check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
            check("divzero", {63'd0, bus.divzero}, {63'd0, e.dz});
          end
          run = 0;
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    n_checks = 0;
    n_fail   = 0;
    reset_n       = 1'b0;
    bus.startE    = 1'b0;
    bus.opE       = 2'b00;
    bus.srcaE     = '0;
    bus.srcbE     = '0;
    bus.mthiE     = 1'b0;
    bus.mtloE     = 1'b0;
    bus.hiloreadD = 1'b0;
    bus.muldivD   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy",    {63'd0, bus.busy},    64'd0);
    check("rst_mdstall", {63'd0, bus.mdstall}, 64'd0);
    check("rst_hi",      {32'd0, bus.hi},      64'd0);
    check("rst_lo",      {32'd0, bus.lo},      64'd0);
    check("rst_divzero", {63'd0, bus.divzero}, 64'd0);
    #1 reset_n = 1'b1;

    // MTHI / MTLO single-cycle writes.
    @(negedge clk);
    bus.mthiE = 1'b1; bus.srcaE = 32'h1234_5678;
    @(negedge clk);
    bus.mthiE = 1'b0;
    #1 check("mthi", {32'd0, bus.hi}, 64'h0000_0000_1234_5678);
    @(negedge clk);
    bus.mtloE = 1'b1; bus.srcaE = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mtloE = 1'b0;
    #1 check("mtlo", {32'd0, bus.lo}, 64'h0000_0000_CAFE_F00D);

    // MULT 7 x 6, with MFHI held in Decode and MTHI attempted while busy.
    start_op(OP_MULT, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 1'b0, 1'b1);
    bus.hiloreadD = 1'b1;
    bus.mthiE     = 1'b1;
    bus.srcaE     = 32'hDEAD_BEEF;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("mdstall_busy", {63'd0, bus.mdstall}, 64'd1);
      check("hi_hold",      {32'd0, bus.hi},      64'h0000_0000_1234_5678);
      @(negedge clk);
    end
    #1 check("mdstall_after", {63'd0, bus.mdstall}, 64'd0);
    bus.hiloreadD = 1'b0;
    bus.mthiE     = 1'b0;

    // Directed arithmetic vectors.
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op(OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // Asynchronous reset in the middle of a MULT.
    start_op(OP_MULT, 32'h0000_1234, 32'h0000_5678, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy",    {63'd0, bus.busy},    64'd0);
    check("arst_hi",      {32'd0, bus.hi},      64'd0);
    check("arst_lo",      {32'd0, bus.lo},      64'd0);
    check("arst_divzero", {63'd0, bus.divzero}, 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    run_op(OP_MULT, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with HI/LO registers for the pipelined MIPS core. It runs MULT, MULTU, DIV and DIVU launched from the Execute stage, and services MTHI/MTLO and MFHI/MFLO. While an operation is in flight it raises a stall request to the hazard unit. The hazard unit ORs this request into stallF/stallD/flushE, so this block is the producing end of the stall protocol.

## Interface
- WIDTH, 32, operand/HI/LO width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- startE  in  1  mul/div instruction valid in Execute.
- opE  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcaE  in  WIDTH  rs operand, after forwarding.
- srcbE  in  WIDTH  rt operand, after forwarding.
- mthiE  in  1  MTHI in Execute; writes HI with srcaE.
- mtloE  in  1  MTLO in Execute; writes LO with srcaE.
- hiloreadD  in  1  MFHI/MFLO in Decode.
- muldivD  in  1  MULT/DIV/MTHI/MTLO in Decode.
- busy  out  1  an operation is in flight.
- mdstall  out  1  stall request to the hazard unit; combinational: busy & (hiloreadD | muldivD).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- divzero  out  1  the last completed DIV/DIVU had a zero divisor; held until the next start.

## Operation
- FSM states: IDLE, MUL, DIV.
- **IDLE, startE=1**: latch |srcaE| and |srcbE| (raw values for unsigned ops) plus the sign flags. Clear count to 0. Go to MUL if opE[1]=0, else DIV. Clear divzero.
- **IDLE, mthiE or mtloE**: write srcaE to HI or LO at the edge. No busy.
- **IDLE, startE together with mthiE or mtloE**: startE wins and the move is dropped. The hazard unit never issues this combination.
- **MUL**: radix-2 shift-add, one bit per cycle, 64-bit product accumulator.
- **DIV**: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- **count**: 6 bits, increments every cycle in MUL/DIV. On the iteration where count=31, write the results and go to IDLE.
- **Signed fixup, same edge as the write-back**:
  - Product is negated when sign(a)^sign(b).
  - Quotient is negated when sign(a)^sign(b).
  - Remainder takes the sign of a.
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- **Divide by zero**: the operation still runs 32 cycles. LO = 0xFFFFFFFF, HI = srcaE as latched (raw), divzero=1.
- **Signed overflow** 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude path with no special case.
- **While busy**: startE, mthiE and mtloE are ignored. HI/LO hold their old values until the write-back.
- mdstall is combinational. The hazard unit uses it to hold F/D and bubble E until busy falls.

## Timing
- **Reset** (asynchronous, any time, including mid-operation): state=IDLE, count=0, busy=0, mdstall=0, hi=0, lo=0, divzero=0, accumulators=0.
- **Start**: startE is sampled at edge N while IDLE.
- **busy**: 1 from edge N through edge N+32, i.e. exactly 32 cycles.
- **Write-back**: HI/LO/divzero updated at edge N+32; busy=0 after the same edge.
- **Reading results**: an MFHI/MFLO held in Decode sees mdstall=0 in the cycle after edge N+32 and reads the new HI/LO. No bypass of in-flight results exists.
- **Back-to-back**: a new startE is accepted at edge N+33 at the earliest.
- **MTHI/MTLO**: 1-cycle write, visible on hi/lo after the edge.
- **Total latency**: 32 cycles for every op and operand value. There is no early termination.

## Test plan
- MULT 7 × 6 at edge N: busy high for exactly 32 cycles; at edge N+32, HI=0x00000000 and LO=0x0000002A.
- MULT 0xFFFFFFFD × 5 (−3 × 5): HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 / 2 (−7 / 2): LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7: LO=14, HI=2, divzero=0.
- DIVU 100 / 0: LO=0xFFFFFFFF, HI=100, divzero=1. DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- hiloreadD=1 held from cycle N+1 onward: mdstall=1 through the cycle ending at edge N+32, then 0. mthiE asserted during busy leaves HI unchanged before the write-back.
- reset_n pulsed low at cycle N+10 of a MULT: busy, hi, lo and divzero go to 0 immediately (asynchronously). A following MULT 3 × 3 completes normally with LO=9 after 32 cycles.
